// File: rtl/event_peak_tracker_pkg.sv
// Shared types and helpers for the event peak tracker: sample width, FSM state
// encoding and the saturating adder used to form the trigger level.
package event_pkg;

    localparam int DATA_W = 20;

    typedef enum logic [2:0] {
        SETTLE    = 3'd0,
        ARMED     = 3'd1,
        IN_EVENT  = 3'd2,
        TRAILING  = 3'd3,
        RPT_SETUP = 3'd4,
        RPT       = 3'd5
    } tracker_state_t;

    // Unsigned add that clamps to all-ones instead of wrapping.
    function automatic logic [DATA_W-1:0] sat_add(input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b);
        logic [DATA_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[DATA_W] ? {DATA_W{1'b1}} : sum[DATA_W-1:0];
    endfunction

endpackage

// File: rtl/event_peak_tracker_baseline_ema.sv
// Combinational EMA step: next = baseline + ((sample - baseline) >>> AVG_SHIFT).
// The arithmetic shift rounds toward -inf, so the result never leaves [0, 2^DATA_W-1].
module baseline_ema
    import event_pkg::*;
#(
    parameter int AVG_SHIFT = 3
) (
    input  logic [DATA_W-1:0] sample,
    input  logic [DATA_W-1:0] baseline,
    output logic [DATA_W-1:0] next_baseline
);

    logic signed [DATA_W:0] diff;
    logic signed [DATA_W:0] delta;

    assign diff  = $signed({1'b0, sample}) - $signed({1'b0, baseline});
    assign delta = diff >>> AVG_SHIFT;

    // Carry out of the top bit is discarded; the true sum is always in range.
    assign next_baseline = DATA_W'({1'b0, baseline} + $unsigned(delta));

endmodule

// File: rtl/event_peak_tracker.sv
// Event qualifier: EMA baseline tracking, event detection above baseline+threshold,
// peak capture and a registered baseline/peak report with a one-cycle enable.
//
// state     | meaning
// SETTLE    | baseline warming up, no triggering
// ARMED     | baseline tracking, waiting for sample > trig_level
// IN_EVENT  | samples above trig_level, tracking the peak
// TRAILING  | counting consecutive at/below-level samples
// RPT_SETUP | load output pair from frozen baseline and peak
// RPT       | raise useful_event_enable, then back to ARMED
module event_peak_tracker
    import event_pkg::*;
#(
    parameter int AVG_SHIFT         = 3,
    parameter int SETTLE_SAMPLES    = 8,
    parameter int HOLD_SAMPLES      = 4,
    parameter int MAX_EVENT_SAMPLES = 1024
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample,
    input  logic [DATA_W-1:0] threshold,
    output logic [DATA_W-1:0] baseline_value,
    output logic [DATA_W-1:0] current_maximum_value,
    output logic              useful_event_enable,
    output logic              busy,
    output logic              sample_overrun
);

    localparam int SETTLE_W = $clog2(SETTLE_SAMPLES + 1);
    localparam int HOLD_W   = $clog2(HOLD_SAMPLES + 1);
    localparam int LEN_W    = $clog2(MAX_EVENT_SAMPLES + 1);

    tracker_state_t    state;
    logic [DATA_W-1:0] baseline;
    logic [DATA_W-1:0] peak;
    logic [DATA_W-1:0] trig_level;
    logic [DATA_W-1:0] ema_next;
    logic [DATA_W-1:0] peak_next;
    logic              first_seen;
    logic [SETTLE_W-1:0] settle_cnt;
    logic [HOLD_W-1:0]   hold_cnt;
    logic [HOLD_W-1:0]   hold_next;
    logic [LEN_W-1:0]    len_cnt;
    logic [LEN_W-1:0]    len_next;
    logic              above;
    logic              cap_hit;

    baseline_ema #(
        .AVG_SHIFT(AVG_SHIFT)
    ) u_ema (
        .sample       (sample),
        .baseline     (baseline),
        .next_baseline(ema_next)
    );

    assign trig_level = sat_add(baseline, threshold);
    assign above      = sample > trig_level;
    assign peak_next  = (sample > peak) ? sample : peak;
    assign len_next   = len_cnt + LEN_W'(1);
    assign hold_next  = hold_cnt + HOLD_W'(1);
    assign cap_hit    = len_next == LEN_W'(MAX_EVENT_SAMPLES);
    assign busy       = (state == IN_EVENT) || (state == TRAILING) ||
                        (state == RPT_SETUP) || (state == RPT);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state                 <= SETTLE;
            baseline              <= '0;
            peak                  <= '0;
            first_seen            <= 1'b0;
            settle_cnt            <= '0;
            hold_cnt              <= '0;
            len_cnt               <= '0;
            baseline_value        <= '0;
            current_maximum_value <= '0;
            useful_event_enable   <= 1'b0;
            sample_overrun        <= 1'b0;
        end else begin
            useful_event_enable <= 1'b0;
            sample_overrun      <= 1'b0;
            case (state)
                SETTLE: begin
                    if (sample_valid) begin
                        first_seen <= 1'b1;
                        baseline   <= first_seen ? ema_next : sample;
                        settle_cnt <= settle_cnt + SETTLE_W'(1);
                        if (settle_cnt == SETTLE_W'(SETTLE_SAMPLES - 1)) begin
                            state <= ARMED;
                        end
                    end
                end
                ARMED: begin
                    if (sample_valid) begin
                        if (above) begin
                            state    <= IN_EVENT;
                            peak     <= sample;
                            len_cnt  <= LEN_W'(1);
                            hold_cnt <= '0;
                        end else begin
                            baseline <= ema_next;
                        end
                    end
                end
                IN_EVENT: begin
                    if (sample_valid) begin
                        peak    <= peak_next;
                        len_cnt <= len_next;
                        if (cap_hit) begin
                            state <= RPT_SETUP;
                        end else if (!above) begin
                            hold_cnt <= HOLD_W'(1);
                            state    <= (HOLD_SAMPLES <= 1) ? RPT_SETUP : TRAILING;
                        end
                    end
                end
                TRAILING: begin
                    if (sample_valid) begin
                        peak    <= peak_next;
                        len_cnt <= len_next;
                        if (cap_hit) begin
                            state <= RPT_SETUP;
                        end else if (above) begin
                            hold_cnt <= '0;
                            state    <= IN_EVENT;
                        end else begin
                            hold_cnt <= hold_next;
                            if (hold_next == HOLD_W'(HOLD_SAMPLES)) begin
                                state <= RPT_SETUP;
                            end
                        end
                    end
                end
                RPT_SETUP: begin
                    baseline_value        <= baseline;
                    current_maximum_value <= peak;
                    sample_overrun        <= sample_valid;
                    state                 <= RPT;
                end
                RPT: begin
                    useful_event_enable <= 1'b1;
                    sample_overrun      <= sample_valid;
                    state               <= ARMED;
                end
                default: state <= SETTLE;
            endcase
        end
    end

endmodule
